// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the serial ALU sequencer: state/payload enums, word geometry, parity.
// Words are 10 bits, MSB first: {payload type, byte, even parity over the upper nine bits}.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        WAIT_RSP = 3'd2,
        RECV     = 3'd3,
        DONE     = 3'd4
    } state_t;

    typedef enum logic {
        DATA = 1'b0,
        CMD  = 1'b1
    } ptype_t;

    localparam int WORD_W      = 10;
    localparam int FRAME_WORDS = 3;
    localparam int FRAME_W     = WORD_W * FRAME_WORDS;

    function automatic logic parity(input logic [WORD_W-2:0] x);
        return ^x;
    endfunction

    function automatic logic [WORD_W-1:0] mk_word(input ptype_t t, input logic [7:0] b);
        return {t, b, parity({t, b})};
    endfunction

endpackage

// File: rtl/alu_seq_deser.sv
// Receive shifter: collects the 30-bit response frame MSB first and flags per-word parity errors.
// Zero latency on outputs (decoded straight from the register); no backpressure, shifts whenever enabled.
module alu_seq_deser
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       shift_en,
    input  logic       din,
    output logic [7:0] status,
    output logic [7:0] data_msb,
    output logic [7:0] data_lsb,
    output logic [2:0] par_err
);

    logic [FRAME_W-1:0] frame;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame <= '0;
        end else if (clr) begin
            frame <= '0;
        end else if (shift_en) begin
            frame <= {frame[FRAME_W-2:0], din};
        end
    end

    // Word 2 is the status word (received first), word 0 the data LSB word.
    always_comb begin
        par_err = '0;
        for (int i = 0; i < FRAME_WORDS; i++) begin
            par_err[i] = parity(frame[i*WORD_W+1 +: WORD_W-1]) != frame[i*WORD_W];
        end
    end

    assign status   = frame[2*WORD_W+1 +: 8];
    assign data_msb = frame[WORD_W+1 +: 8];
    assign data_lsb = frame[1 +: 8];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Serial ALU sequencer: accepts one request, shifts out A/B/op words, deserialises status/MSB/LSB response.
// Response valid the cycle after the last received bit, held until rsp_ready; ALU_SEQ_TIMEOUT_EN adds a WAIT_RSP watchdog.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [7:0]  req_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_status,
    output logic [15:0] rsp_data,
    output logic        rsp_par_err,
    output logic        rsp_timeout,
    output logic        alu_enable_n,
    output logic        alu_din,
    input  logic        alu_dout,
    input  logic        alu_dout_valid
);

    state_t             state, state_nxt;
    logic [4:0]         bit_cnt;
    logic [FRAME_W-1:0] tx_frame;
    logic               accept;
    logic               shift_en;
    logic               timeout_hit;
    logic [7:0]         rx_msb, rx_lsb;
    logic [2:0]         rx_par_err;

    assign accept = (state == IDLE) && req_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            tx_frame <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                bit_cnt <= '0;
            end else if (bit_cnt != 5'd31) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (accept) begin
                tx_frame <= {mk_word(DATA, req_a), mk_word(DATA, req_b), mk_word(CMD, req_op)};
            end else if (state == SEND) begin
                tx_frame <= {tx_frame[FRAME_W-2:0], 1'b0};
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_enable_n = 1'b1;
        alu_din      = 1'b0;
        shift_en     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = SEND;
            end
            SEND: begin
                alu_enable_n = 1'b0;
                alu_din      = tx_frame[FRAME_W-1];
                if (bit_cnt == 5'(FRAME_W - 1)) state_nxt = WAIT_RSP;
            end
            WAIT_RSP: begin
                // The first valid edge already carries status bit 9.
                if (alu_dout_valid) begin
                    shift_en  = 1'b1;
                    state_nxt = RECV;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            RECV: begin
                shift_en = 1'b1;
                if (bit_cnt == 5'(FRAME_W - 2)) state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Cleared on acceptance so a timed-out response reads back as all zeros with clean parity.
    alu_seq_deser u_deser (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (accept),
        .shift_en (shift_en),
        .din      (alu_dout),
        .status   (rsp_status),
        .data_msb (rx_msb),
        .data_lsb (rx_lsb),
        .par_err  (rx_par_err)
    );

    assign rsp_data    = {rx_msb, rx_lsb};
    assign rsp_par_err = |rx_par_err;

`ifdef ALU_SEQ_TIMEOUT_EN
    logic [31:0] wait_cnt;
    logic        timeout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT_RSP) ? wait_cnt + 32'd1 : '0;
            if (accept) begin
                timeout_q <= 1'b0;
            end else if (timeout_hit && !alu_dout_valid) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout_hit = (state == WAIT_RSP) && (wait_cnt == 32'(TIMEOUT_CYC - 1));
    assign rsp_timeout = timeout_q;
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign timeout_hit        = 1'b0;
    assign rsp_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Randomised scoreboard bench for alu_seq_ctrl with a serial ALU responder model.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [7:0]  req_a, req_b, req_op;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_status;
    logic [15:0] rsp_data;
    logic        rsp_par_err, rsp_timeout;
    logic        alu_enable_n, alu_din, alu_dout, alu_dout_valid;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_status(rsp_status), .rsp_data(rsp_data),
        .rsp_par_err(rsp_par_err), .rsp_timeout(rsp_timeout),
        .alu_enable_n(alu_enable_n), .alu_din(alu_din),
        .alu_dout(alu_dout), .alu_dout_valid(alu_dout_valid)
    );

    // mode: 0 clean, 1/2/3 corrupt parity of status/MSB/LSB word, 4 ALU stays silent
    typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] op; int mode; } item_t;
    typedef struct { logic [7:0] status; logic [15:0] data; logic par; logic to; } exp_t;

    item_t       alu_q[$];
    exp_t        sb_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic        hold_rdy = 1'b0;
    logic [29:0] last_frame = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [9:0] w(input logic t, input logic [7:0] b);
        return {t, b, ^{t, b}};
    endfunction

    // Behaviour of the ALU on the far side, and hence what the controller must return.
    function automatic exp_t ref_rsp(input item_t it);
        exp_t e;
        e.status = it.op - 8'd1;
        e.data   = (it.op == 8'd1) ? 16'(it.a) + 16'(it.b) : 16'(it.a) * 16'(it.b);
        e.par    = (it.mode >= 1 && it.mode <= 3);
        e.to     = 1'b0;
        if (it.mode == 4) begin
            e.status = '0;
            e.data   = '0;
            e.to     = 1'b1;
        end
        return e;
    endfunction

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input int mode);
        item_t it;
        int    k;
        it.a = a; it.b = b; it.op = op; it.mode = mode;
        alu_q.push_back(it);
        sb_q.push_back(ref_rsp(it));
        @(posedge clk); #1;
        req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
        k = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (req_ready !== 1'b1) chk("req_accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("drain", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin : rdy_driver
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(2) != 0);
        end
    end

    initial begin : alu_model
        item_t       it;
        exp_t        e;
        logic [29:0] frame, resp;
        int          n;
        alu_dout = 1'b0;
        alu_dout_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (alu_enable_n === 1'b0) begin
                frame = '0;
                n = 0;
                while (alu_enable_n === 1'b0 && n < 40) begin
                    frame = {frame[28:0], alu_din};
                    n++;
                    alu_dout_valid = ($urandom_range(1) != 0);
                    @(negedge clk);
                end
                alu_dout_valid = 1'b0;
                if (alu_q.size() == 0) begin
                    chk("aborted_len", 32'(n), 32'd15);
                end else begin
                    it = alu_q.pop_front();
                    last_frame = frame;
                    chk("en_len", 32'(n), 32'd30);
                    chk("frame", 32'(frame), 32'({w(1'b0, it.a), w(1'b0, it.b), w(1'b1, it.op)}));
                    if (it.mode != 4) begin
                        e = ref_rsp(it);
                        resp = {w(1'b1, e.status), w(1'b0, e.data[15:8]), w(1'b0, e.data[7:0])};
                        if (it.mode == 1) resp[20] = ~resp[20];
                        if (it.mode == 2) resp[10] = ~resp[10];
                        if (it.mode == 3) resp[0]  = ~resp[0];
                        repeat ($urandom_range(4)) @(negedge clk);
                        for (int i = 0; i < 30; i++) begin
                            alu_dout = resp[29-i];
                            alu_dout_valid = (i == 0) ? 1'b1 : ($urandom_range(1) != 0);
                            @(negedge clk);
                        end
                        alu_dout = 1'b0;
                        alu_dout_valid = 1'b0;
                        chk("rsp_latency", 32'(rsp_valid), 32'd1);
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t        e;
        logic        pv;
        logic [7:0]  ps;
        logic [15:0] pd;
        pv = 1'b0; ps = '0; pd = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                pv = 1'b0;
            end else begin
                if (alu_enable_n === 1'b1) chk("din_idle", 32'(alu_din), 32'd0);
                if (rsp_valid === 1'b1) begin
                    chk("req_ready_busy", 32'(req_ready), 32'd0);
                    if (pv) begin
                        chk("hold_status", 32'(rsp_status), 32'(ps));
                        chk("hold_data", 32'(rsp_data), 32'(pd));
                    end
                    if (rsp_ready) begin
                        pv = 1'b0;
                        if (sb_q.size() == 0) begin
                            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                        end else begin
                            e = sb_q.pop_front();
                            chk("rsp_status", 32'(rsp_status), 32'(e.status));
                            chk("rsp_data", 32'(rsp_data), 32'(e.data));
                            chk("rsp_par_err", 32'(rsp_par_err), 32'(e.par));
                            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                        end
                    end else begin
                        pv = 1'b1; ps = rsp_status; pd = rsp_data;
                    end
                end else begin
                    pv = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_status", 32'(rsp_status), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        chk("rst_par_err", 32'(rsp_par_err), 32'd0);
        chk("rst_timeout", 32'(rsp_timeout), 32'd0);
        chk("rst_enable_n", 32'(alu_enable_n), 32'd1);
        chk("rst_din", 32'(alu_din), 32'd0);

        // Directed: known frame and clean response 0x0046
        issue(8'h12, 8'h34, 8'h01, 0);
        drain();
        chk("frame_literal", 32'(last_frame), 32'(30'b0000100100_0001101001_1000000010));

        // Directed: corrupted LSB parity still returns the bytes
        issue(8'h12, 8'h34, 8'h01, 3);
        drain();

        // Directed: consumer stalls; monitor checks stability and req_ready while held
        hold_rdy = 1'b1;
        issue(8'h05, 8'h07, 8'h02, 0);
        k = 0;
        while (rsp_valid !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        repeat (5) @(negedge clk);
        chk("held_valid", 32'(rsp_valid), 32'd1);
        chk("held_req_ready", 32'(req_ready), 32'd0);
        hold_rdy = 1'b0;
        drain();

        // Reset during the 15th SEND bit aborts without a response
        @(posedge clk); #1;
        req_valid = 1'b1; req_a = 8'hAA; req_b = 8'h55; req_op = 8'h03;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        @(negedge clk);
        while (alu_enable_n !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_enable_n", 32'(alu_enable_n), 32'd1);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            issue(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(3)));
        end
        drain();

`ifdef ALU_SEQ_TIMEOUT_EN
        issue(8'h21, 8'h43, 8'h01, 4);
        drain();
        issue(8'h01, 8'h02, 8'h01, 0);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
